// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I fetch stage. Holds the PC, issues one word request at a
// time to instruction memory (req/gnt/rvalid) and hands the fetched instruction
// and its PC to decode over a valid/ready handshake. A redirect loads a new PC
// and kills the fetch in flight.
//
// Ports:
//   clk, rst_n            core clock (rising edge), async active-low reset
//   imem_req_o            fetch request valid (decoded from state)
//   imem_addr_o           fetch byte address, word aligned (the pc register)
//   imem_gnt_i            memory accepts the request this cycle
//   imem_rvalid_i         read data valid
//   imem_rdata_i          read data
//   redirect_i            load redirect_pc_i into the PC, kill current fetch
//   redirect_pc_i         redirect target (low two bits ignored)
//   instr_o, pc_o         instruction to decode and its PC (registered)
//   instr_valid_o         instr_o/pc_o valid (registered)
//   instr_ready_i         decode accepts the instruction
module instr_fetch_unit #(
  parameter int unsigned          XLEN       = 32,
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [XLEN-1:0]       imem_rdata_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic [XLEN-1:0]       instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i
);

  localparam logic [XLEN-1:0]       NOP_INSTR  = XLEN'(32'h0000_0013);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]         instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]   pc_out_q, pc_out_d;
  logic                    valid_q, valid_d;
  logic [ADDR_WIDTH-1:0]   redirect_target;

  assign redirect_target = redirect_pc_i & ALIGN_MASK;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pc_out_q <= RESET_PC;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

  // Next-state logic; a redirect overrides every other event in the cycle.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;

    if (redirect_i) begin
      pc_d    = redirect_target;
      valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        // A grant alongside a redirect leaves a response outstanding.
        if (imem_gnt_i) state_d = redirect_i ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (redirect_i) begin
          state_d = imem_rvalid_i ? S_REQ : S_DRAIN;
        end else if (imem_rvalid_i) begin
          instr_d  = imem_rdata_i;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_i) begin
          state_d = S_REQ;
        end else if (valid_q && instr_ready_i) begin
          pc_d    = pc_q + PC_STEP;
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        // The stale response is dropped; fetch resumes at the latest PC.
        if (imem_rvalid_i) state_d = S_REQ;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Request decoded from state only: no input-to-output path.
  assign imem_req_o    = (state_q == S_REQ);
  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_out_q;
  assign instr_valid_o = valid_q;

endmodule
